// File: rtl/conv_output_writer.sv
// Requantizes MAC accumulator results to signed 8 bits and streams them into the output RAM.
// Optional macro CONV_OUT_RELU_EN clamps negative quantized pixels to zero after saturation.
module conv_output_writer #(
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned NUM_OUT = 128,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              conv_run_i,
  input  logic              mac_valid_i,
  input  logic [ACC_W-1:0]  mac_result_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o,
  output logic              conv_done_o,
  output logic              sat_flag_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [ADDR_W-1:0]       LastIdx = ADDR_W'(NUM_OUT - 1);
  localparam logic signed [ACC_W-1:0] QMax    = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] QMin    = ACC_W'(-128);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              sat_q, sat_d;

  logic signed [ACC_W-1:0] q;
  logic                    sat_hi, sat_lo;
  logic [7:0]              quant;

  // Arithmetic shift gives floor rounding for negative sums.
  assign q      = $signed(mac_result_i) >>> SHIFT;
  assign sat_hi = (q > QMax);
  assign sat_lo = (q < QMin);

  always_comb begin
    if (sat_hi) begin
      quant = 8'h7F;
    end else if (sat_lo) begin
      quant = 8'h80;
    end else begin
      quant = q[7:0];
    end
`ifdef CONV_OUT_RELU_EN
    if (quant[7]) begin
      quant = 8'h00;
    end
`else
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sat_d     = sat_q;
    unique case (state_q)
      StIdle: begin
        if (conv_run_i) begin
          state_d = StRun;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      StRun: begin
        if (!conv_run_i) begin
          // Abort drops any coincident result; sat flag survives until next start.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (mac_valid_i) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = quant;
          sat_d     = sat_q | sat_hi | sat_lo;
          if (cnt_q == LastIdx) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (!conv_run_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sat_q     <= sat_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = (state_q == StRun);
  assign conv_done_o = (state_q == StDone);
  assign sat_flag_o  = sat_q;

endmodule

// File: tb/tb_conv_output_writer.sv
// Scoreboard bench for conv_output_writer: expected writes are queued at stimulus time and a
// monitor pops them whenever wr_en_o is seen.
module tb_conv_output_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        conv_run;
  logic        mac_valid;
  logic [19:0] mac_result;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        conv_done;
  logic        sat_flag;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  conv_output_writer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .conv_run_i   (conv_run),
    .mac_valid_i  (mac_valid),
    .mac_result_i (mac_result),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .busy_o       (busy),
    .conv_done_o  (conv_done),
    .sat_flag_o   (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one result; the write is expected on the next edge.
  task automatic mac(input logic [19:0] v, input logic [7:0] ea, input logic [7:0] ed);
    exp_t e;
    e.addr = ea;
    e.data = ed;
    e.cyc  = cyc + 1;
    sb.push_back(e);
    mac_valid  = 1'b1;
    mac_result = v;
    step();
    mac_valid  = 1'b0;
  endtask

  // Result that must not produce a write.
  task automatic mac_drop(input logic [19:0] v);
    mac_valid  = 1'b1;
    mac_result = v;
    step();
    mac_valid  = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", wr_addr,
                   wr_data);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
          chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
          chk("wr_latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

`ifdef CONV_OUT_RELU_EN
  localparam logic [7:0] NegSmall = 8'h00;
  localparam logic [7:0] NegMin   = 8'h00;
  localparam logic [7:0] NegSat   = 8'h00;
`else
  localparam logic [7:0] NegSmall = 8'hF9;
  localparam logic [7:0] NegMin   = 8'h80;
  localparam logic [7:0] NegSat   = 8'h80;
`endif

  initial begin
    rst_n      = 1'b0;
    conv_run   = 1'b0;
    mac_valid  = 1'b0;
    mac_result = '0;
    #12;
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, conv_done}, 0);
    chk("rst_sat", {31'd0, sat_flag}, 0);
    step();
    rst_n = 1'b1;
    mac_drop(20'd800);  // ignored in IDLE

    // Run A: quantization corners without saturation, then saturation.
    conv_run = 1'b1;
    step();
    chk("runA_busy", {31'd0, busy}, 1);
    mac(20'd800, 8'd0, 8'h32);
    mac(-20'sd100, 8'd1, NegSmall);  // -6.25 floors to -7
    mac(20'd2047, 8'd2, 8'h7F);
    mac(-20'sd2048, 8'd3, NegMin);
    chk("runA_no_sat", {31'd0, sat_flag}, 0);
    mac(20'd5000, 8'd4, 8'h7F);
    chk("runA_sat_hi", {31'd0, sat_flag}, 1);
    step();

    // Asynchronous reset mid-run.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 0);
    chk("async_rst_sat", {31'd0, sat_flag}, 0);
    chk("async_rst_addr", {24'd0, wr_addr}, 0);
    chk("async_rst_data", {24'd0, wr_data}, 0);
    conv_run = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Run B: negative saturation, then abort after 10 writes.
    conv_run = 1'b1;
    step();
    mac(-20'sd3000, 8'd0, NegSat);
    chk("runB_sat_lo", {31'd0, sat_flag}, 1);
    for (int k = 1; k < 10; k++) begin
      mac(20'(16 * k), 8'(k), 8'(k));
    end
    conv_run = 1'b0;
    mac_drop(20'd160);
    chk("abort_idle", {31'd0, busy}, 0);
    chk("abort_no_done", {31'd0, conv_done}, 0);
    chk("abort_sat_held", {31'd0, sat_flag}, 1);
    mac_drop(20'd160);

    // Run C: full 128-pixel run, back-to-back.
    conv_run = 1'b1;
    step();
    chk("runC_sat_cleared", {31'd0, sat_flag}, 0);
    for (int i = 0; i < 128; i++) begin
      mac(20'(16 * i), 8'(i), 8'(i));
    end
    step();
    chk("runC_done", {31'd0, conv_done}, 1);
    chk("runC_not_busy", {31'd0, busy}, 0);
    mac_drop(20'd16);
    for (int j = 0; j < 20; j++) begin
      step();
      chk("done_hold", {31'd0, conv_done}, 1);
    end
    conv_run = 1'b0;
    step();
    chk("done_release", {31'd0, conv_done}, 0);
    chk("idle_after_done", {31'd0, busy}, 0);
    step();
    step();
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
